// File: rtl/id_pkg.sv
// Shared types and default constants for the decode (ID) stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package id_pkg;

    // Immediate field layouts selectable by the decoder
    typedef enum logic [1:0] {
        IMM_DT9   = 2'd0,
        IMM_ALU12 = 2'd1,
        IMM_CB19  = 2'd2,
        IMM_B26   = 2'd3
    } imm_sel_e;

    localparam int DATA_W_DEF   = 64;
    localparam int NREG_DEF     = 32;
    localparam int LOAD_LAT_DEF = 1;

    // Width of each per-register load-use countdown
    localparam int CNT_W = 3;

endpackage

// File: rtl/id_regfile_p.sv
// Two-read / one-write register file with a hardwired zero register.
// Latency: reads combinational, a same-cycle writeback is forwarded to readers.
// Backpressure: none; writes are accepted every cycle.
module id_regfile_p #(
    parameter int DATA_W   = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = NREG - 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     rb,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [DATA_W-1:0] mem [NREG];

    // Writeback storage; the zero register is never written so it stays clean
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wb_en && wb_addr != ZR) begin
            mem[wb_addr] <= wb_data;
        end
    end

    // Zero register wins over the bypass so a write attempt to it never leaks out
    assign rdata_a = (ra == ZR) ? '0 : (wb_en && wb_addr == ra) ? wb_data : mem[ra];
    assign rdata_b = (rb == ZR) ? '0 : (wb_en && wb_addr == rb) ? wb_data : mem[rb];

endmodule

// File: rtl/id_stage_p.sv
// Decode stage: register read, immediate extension, load-use interlock, ID/EX register.
// Latency: one cycle from accept to out_* valid.
// Backpressure: in_ready drops on a full, unconsumed ID/EX register, a load-use hazard or flush.
module id_stage_p
    import id_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int ZERO_REG = NREG - 1,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rn,
    input  logic [AW-1:0]     in_rm,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_reg2loc,
    input  logic [25:0]       in_imm_raw,
    input  logic [1:0]        in_imm_sel,
    input  logic              in_regwrite,
    input  logic              in_memread,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_da,
    output logic [DATA_W-1:0] out_db,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic [AW-1:0]     out_rd,
    output logic              out_regwrite,
    output logic              out_memread
);

    localparam logic [AW-1:0]    ZR  = AW'(ZERO_REG);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(LOAD_LAT);

    logic [AW-1:0]     rb_addr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] imm;
    logic [CNT_W-1:0]  cnt [NREG];
    logic              hz_a;
    logic              hz_b;
    logic              hazard;
    logic              accept;
    logic              load_set;
    logic              flush_clr;

    assign rb_addr = in_reg2loc ? in_rd : in_rm;

    id_regfile_p #(
        .DATA_W   (DATA_W),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra      (in_rn),
        .rb      (rb_addr),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    // Sign-extend the selected immediate field; shifting is left to EX
    always_comb begin
        imm = '0;
        case (imm_sel_e'(in_imm_sel))
            IMM_DT9:   imm = {{(DATA_W-9){in_imm_raw[8]}},   in_imm_raw[8:0]};
            IMM_ALU12: imm = {{(DATA_W-12){in_imm_raw[11]}}, in_imm_raw[11:0]};
            IMM_CB19:  imm = {{(DATA_W-19){in_imm_raw[18]}}, in_imm_raw[18:0]};
            IMM_B26:   imm = {{(DATA_W-26){in_imm_raw[25]}}, in_imm_raw[25:0]};
            default:   imm = '0;
        endcase
    end

    // The zero register is masked explicitly; its counter is never armed anyway
    assign hz_a      = (in_rn != ZR) && (cnt[in_rn] != '0);
    assign hz_b      = (rb_addr != ZR) && (cnt[rb_addr] != '0);
    assign hazard    = in_valid && (hz_a || hz_b);
    assign in_ready  = (!out_valid || out_ready) && !hazard && !flush;
    assign accept    = in_valid && in_ready;
    assign load_set  = accept && in_memread && in_regwrite && (in_rd != ZR);
    assign flush_clr = flush && out_valid && out_memread && out_regwrite;

    // Load-use countdowns: arm on load accept, drop a squashed load, else count down
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (load_set && in_rd == AW'(i)) begin
                    cnt[i] <= LAT;
                end else if (flush_clr && out_rd == AW'(i)) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // ID/EX register: payload only loads on accept, so a stalled entry never re-reads the regfile
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_da       <= '0;
            out_db       <= '0;
            out_imm      <= '0;
            out_pc       <= '0;
            out_rd       <= '0;
            out_regwrite <= 1'b0;
            out_memread  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_da       <= rd_a;
            out_db       <= rd_b;
            out_imm      <= imm;
            out_pc       <= in_pc;
            out_rd       <= in_rd;
            out_regwrite <= in_regwrite;
            out_memread  <= in_memread;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_p.sv
// Directed bench for id_stage_p with an expected-output queue and a small register model.
// Latency: checks each accepted instruction one cycle after accept.
// Backpressure: exercises load-use stalls, EX hold and flush.
module tb_id_stage_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rn, in_rm, in_rd;
    logic        in_reg2loc;
    logic [25:0] in_imm_raw;
    logic [1:0]  in_imm_sel;
    logic        in_regwrite, in_memread;
    logic [63:0] in_pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_da, out_db, out_imm, out_pc;
    logic [4:0]  out_rd;
    logic        out_regwrite, out_memread;

    always #5 clk = ~clk;

    id_stage_p dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rn        (in_rn),
        .in_rm        (in_rm),
        .in_rd        (in_rd),
        .in_reg2loc   (in_reg2loc),
        .in_imm_raw   (in_imm_raw),
        .in_imm_sel   (in_imm_sel),
        .in_regwrite  (in_regwrite),
        .in_memread   (in_memread),
        .in_pc        (in_pc),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_da       (out_da),
        .out_db       (out_db),
        .out_imm      (out_imm),
        .out_pc       (out_pc),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite),
        .out_memread  (out_memread)
    );

    typedef struct {
        logic [63:0] da, db, imm, pc;
        logic [4:0]  rd;
        logic        rw, mr;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic        pend = 1'b0;
    logic [63:0] rf [32];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mread(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return rf[a];
    endfunction

    function automatic logic [63:0] eimm(input logic [1:0] sel, input logic [25:0] raw);
        case (sel)
            2'd0:    return {{55{raw[8]}}, raw[8:0]};
            2'd1:    return {{52{raw[11]}}, raw[11:0]};
            2'd2:    return {{45{raw[18]}}, raw[18:0]};
            default: return {{38{raw[25]}}, raw};
        endcase
    endfunction

    task automatic tick();
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] = 64'd0;
        end else if (wb_en && wb_addr != 5'd31) begin
            rf[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".da"},  out_da,  cur.da);
        chk({tag, ".db"},  out_db,  cur.db);
        chk({tag, ".imm"}, out_imm, cur.imm);
        chk({tag, ".pc"},  out_pc,  cur.pc);
        chk({tag, ".rd"},  64'(out_rd), 64'(cur.rd));
        chk({tag, ".rw"},  64'(out_regwrite), 64'(cur.rw));
        chk({tag, ".mr"},  64'(out_memread), 64'(cur.mr));
    endtask

    // One cycle: check in_ready, predict the accepted entry, then check it one cycle later
    task automatic step(input logic exp_rdy, input string tag);
        exp_t e;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
        if (in_valid && exp_rdy) begin
            e.da  = mread(in_rn);
            e.db  = mread(in_reg2loc ? in_rd : in_rm);
            e.imm = eimm(in_imm_sel, in_imm_raw);
            e.pc  = in_pc;
            e.rd  = in_rd;
            e.rw  = in_regwrite;
            e.mr  = in_memread;
            q.push_back(e);
            pend = 1'b1;
        end
        tick();
        if (pend) begin
            pend = 1'b0;
            chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
            cur = q.pop_front();
            chk_out(tag);
        end
    endtask

    task automatic set_instr(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                             input logic r2l, input logic [1:0] sel, input logic [25:0] raw,
                             input logic rw, input logic mr, input logic [63:0] pc);
        in_valid    = 1'b1;
        in_rn       = rn;
        in_rm       = rm;
        in_rd       = rd;
        in_reg2loc  = r2l;
        in_imm_sel  = sel;
        in_imm_raw  = raw;
        in_regwrite = rw;
        in_memread  = mr;
        in_pc       = pc;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [63:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_instr(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 26'd0, 1'b0, 1'b0, 64'd0);
        in_valid = 1'b0;
        set_wb(1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 32; i++) rf[i] = 64'hDEAD;
        tick();
        tick();
        reset = 1'b1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.da", out_da, 64'd0);
        chk("rst.imm", out_imm, 64'd0);
        chk("rst.pc", out_pc, 64'd0);

        // Writeback, then read X3 with a same-cycle write-through of X5
        set_wb(1'b1, 5'd3, 64'h1234);
        step(1'b1, "wb3");
        set_wb(1'b1, 5'd5, 64'd7);
        set_instr(5'd3, 5'd5, 5'd1, 1'b0, 2'd1, 26'h7FF, 1'b1, 1'b0, 64'h100);
        step(1'b1, "fwd");
        set_wb(1'b0, 5'd0, 64'd0);
        in_valid = 1'b0;
        step(1'b1, "drain");
        chk("drain.out_valid", 64'(out_valid), 64'd0);
        chk("drain.pc_hold", out_pc, cur.pc);

        // Zero register ignores a same-cycle write; immediate formats
        set_wb(1'b1, 5'd31, 64'd9);
        set_instr(5'd31, 5'd3, 5'd2, 1'b0, 2'd0, 26'h1FF, 1'b1, 1'b0, 64'h104);
        step(1'b1, "dt9_zr");
        set_wb(1'b0, 5'd0, 64'd0);
        set_instr(5'd31, 5'd0, 5'd3, 1'b1, 2'd2, 26'h40000, 1'b0, 1'b0, 64'h108);
        step(1'b1, "cb19_r2l");
        set_instr(5'd0, 5'd0, 5'd0, 1'b0, 2'd3, 26'h2000001, 1'b0, 1'b0, 64'h10C);
        step(1'b1, "b26");

        // Load-use interlock on port A, zero-register load, port B via reg2loc
        set_instr(5'd0, 5'd0, 5'd4, 1'b0, 2'd0, 26'd0, 1'b1, 1'b1, 64'h110);
        step(1'b1, "ld4");
        set_instr(5'd4, 5'd0, 5'd8, 1'b0, 2'd1, 26'd5, 1'b1, 1'b0, 64'h114);
        step(1'b0, "ld_stall");
        chk("ld_stall.out_valid", 64'(out_valid), 64'd0);
        step(1'b1, "ld_go");
        set_instr(5'd0, 5'd0, 5'd31, 1'b0, 2'd0, 26'd0, 1'b1, 1'b1, 64'h118);
        step(1'b1, "ld31");
        set_instr(5'd31, 5'd0, 5'd10, 1'b0, 2'd0, 26'd0, 1'b1, 1'b0, 64'h11C);
        step(1'b1, "zr_nohaz");
        set_instr(5'd0, 5'd0, 5'd7, 1'b0, 2'd0, 26'd0, 1'b1, 1'b1, 64'h120);
        step(1'b1, "ld7");
        set_instr(5'd0, 5'd0, 5'd7, 1'b1, 2'd0, 26'd3, 1'b0, 1'b0, 64'h124);
        step(1'b0, "b_stall");
        step(1'b1, "b_go");

        // EX backpressure: held entry must not pick up a later writeback
        out_ready = 1'b0;
        set_instr(5'd3, 5'd5, 5'd9, 1'b0, 2'd1, 26'd1, 1'b1, 1'b0, 64'h128);
        set_wb(1'b1, 5'd3, 64'hBEEF);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, "hold");
            set_wb(1'b0, 5'd0, 64'd0);
            chk("hold.out_valid", 64'(out_valid), 64'd1);
            chk_out("hold");
        end
        out_ready = 1'b1;
        step(1'b1, "release");

        // Flush with a load in ID/EX, then a dependent read goes straight through
        set_instr(5'd0, 5'd0, 5'd6, 1'b0, 2'd0, 26'd0, 1'b1, 1'b1, 64'h12C);
        step(1'b1, "ld6");
        flush = 1'b1;
        set_instr(5'd6, 5'd6, 5'd11, 1'b0, 2'd0, 26'd2, 1'b1, 1'b0, 64'h130);
        step(1'b0, "flush");
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        step(1'b1, "post_flush");

        // Reset while stalled discards the held entry and clears the regfile
        out_ready = 1'b0;
        set_instr(5'd3, 5'd5, 5'd12, 1'b0, 2'd0, 26'd0, 1'b1, 1'b0, 64'h134);
        step(1'b0, "pre_rst");
        reset = 1'b0;
        tick();
        q.delete();
        reset = 1'b1;
        chk("rst2.out_valid", 64'(out_valid), 64'd0);
        chk("rst2.da", out_da, 64'd0);
        chk("rst2.db", out_db, 64'd0);
        chk("rst2.pc", out_pc, 64'd0);
        chk("rst2.rd", 64'(out_rd), 64'd0);
        chk("rst2.rw", 64'(out_regwrite), 64'd0);
        out_ready = 1'b1;
        step(1'b1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage_p.md
ID_STAGE_P -- requirements
Module: id_stage_p

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  DATA_W, 64, datapath width (>=32).
  NREG, 32, architectural register count (power of 2).
  ZERO_REG, NREG-1, register that reads 0 and ignores writes.
  LOAD_LAT, 1, stall cycles a load result is unavailable to a dependent read (1..7).
REQ-002 Ports, one per line: name, direction, width, meaning. AW = clog2(NREG).
  clk  in  1  the one clock; all state changes on rising edge.
  reset  in  1  synchronous, active-low reset.
  in_valid  in  1  decoded instruction present from IF/ID.
  in_ready  out  1  stage accepts instruction this cycle.
  in_rn, in_rm, in_rd  in  AW each  register fields.
  in_reg2loc  in  1  1: port B reads in_rd; 0: in_rm.
  in_imm_raw  in  26  raw immediate field, LSB-aligned.
  in_imm_sel  in  2  0=DT9, 1=ALU12, 2=CB19, 3=B26.
  in_regwrite, in_memread  in  1 each  instruction writes rd / is a load.
  in_pc  in  DATA_W  instruction PC.
  wb_en  in  1  writeback strobe.
  wb_addr  in  AW  writeback register.
  wb_data  in  DATA_W  writeback value.
  flush  in  1  branch taken in EX; squash ID/EX contents.
  out_valid  out  1  ID/EX register holds valid instruction.
  out_ready  in  1  EX consumes ID/EX contents this cycle.
  out_da, out_db, out_imm, out_pc  out  DATA_W each  operands, extended immediate, PC.
  out_rd  out  AW; out_regwrite, out_memread  out  1 each  registered controls.

Function
REQ-003 Register file: NREG x DATA_W; write at rising edge when wb_en and wb_addr != ZERO_REG.
REQ-004 Reads of ZERO_REG SHALL return 0; a read of wb_addr while wb_en (non-zero reg) SHALL return wb_data same cycle (write-through bypass).
REQ-005 Port B address = in_reg2loc ? in_rd : in_rm.
REQ-006 Immediate: low 9/12/19/26 bits of in_imm_raw per in_imm_sel, sign-extended to DATA_W; no shift applied.
REQ-007 Scoreboard: one 3-bit down-counter per register; nonzero counters decrement by 1 each cycle, saturating at 0.
REQ-008 On accept of a load with in_regwrite and in_rd != ZERO_REG, counter[in_rd] loads LOAD_LAT (overrides decrement).
REQ-009 hazard = in_valid and (counter[in_rn] != 0 or counter[portB addr] != 0); ZERO_REG never hazards.
REQ-010 in_ready = (!out_valid or out_ready) and !hazard and !flush.
REQ-011 Accept = in_valid and in_ready; on accept, all out_* register next-cycle values from current decode; out_valid=1 next cycle.
REQ-012 If out_valid, out_ready and no accept: out_valid=0 next cycle; other out_* hold.
REQ-013 While out_valid and !out_ready: all out_* SHALL hold stable (no re-read of regfile).
REQ-014 flush: out_valid=0 next cycle; if out_valid and out_memread and out_regwrite, counter[out_rd] cleared to 0; no accept that cycle; other counters continue.
REQ-015 flush has priority over out_ready and accept in the same cycle.
REQ-016 Latency: accepted instruction visible on out_* exactly one cycle after accept.

Reset
REQ-017 reset low at rising edge: out_valid=0, all out_* data/control=0, all counters=0, all registers=0.
REQ-018 Reset mid-stall or mid-hold SHALL discard the held instruction; in_ready=1 first cycle after release (no flush).
REQ-019 reset has priority over flush, wb_en and accept.

Structure
REQ-020 Package id_pkg SHALL hold imm_sel enum (IMM_DT9, IMM_ALU12, IMM_CB19, IMM_B26) and default parameter constants.
REQ-021 Register file SHALL be one sub-module id_regfile_p (parametrised DATA_W, NREG, ZERO_REG, with bypass); scoreboard and ID/EX register inline.

Verification
REQ-022 Writeback X3=0x1234 then in_rn=3 -> out_da=0x1234; same-cycle wb X5=7, in_rm=5 -> out_db=7.
REQ-023 Load rd=4 accepted, next instr rn=4, LOAD_LAT=1 -> in_ready=0 one cycle, accepted following cycle.
REQ-024 out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> next instr one cycle later.
REQ-025 Flush while load rd=6 in ID/EX -> out_valid=0 next cycle; following instr reading X6 accepted without stall.
REQ-026 in_imm_sel=DT9, raw=0x1FF -> out_imm all ones; ALU12 raw=0x7FF -> 0x7FF; ZERO_REG write 9 -> reads 0.
REQ-027 reset low during stall -> all outputs 0 next edge; in_ready=1 after release.
